// File: rtl/sa_tile_scheduler_if.sv
// Bundles the controller, tile-buffer and SA_wrapper signals of one tile scheduler.
// Latency: none, wires only.
// Backpressure: the tile-buffer ack and SA valids pace the scheduler; nothing is dropped.
// Signal names are seen from the scheduler: i_* are scheduler inputs, o_* are scheduler outputs.
interface sa_tile_scheduler_if #(
   parameter int A_W  = 12,
   parameter int KT_W = 6
);
   logic            i_start;
   logic [KT_W-1:0] i_k_tiles;
   logic [A_W-1:0]  i_base_addr;
   logic            o_busy;
   logic            o_rd_req;
   logic [A_W-1:0]  o_rd_addr;
   logic            i_rd_ack;
   logic            o_sa_load_flag;
   logic            o_sa_accumulate;
   logic            i_sa_load_weight_vld;
   logic            i_sa_out_vld;
   logic [KT_W-1:0] o_tile_idx;
   logic            o_done;
   logic            o_err;

   // Environment side: controller, tile buffer and SA_wrapper.
   modport master (
      output i_start, i_k_tiles, i_base_addr, i_rd_ack, i_sa_load_weight_vld, i_sa_out_vld,
      input  o_busy, o_rd_req, o_rd_addr, o_sa_load_flag, o_sa_accumulate, o_tile_idx, o_done, o_err
   );

   // Scheduler side.
   modport slave (
      input  i_start, i_k_tiles, i_base_addr, i_rd_ack, i_sa_load_weight_vld, i_sa_out_vld,
      output o_busy, o_rd_req, o_rd_addr, o_sa_load_flag, o_sa_accumulate, o_tile_idx, o_done, o_err
   );
endinterface

// File: rtl/sa_tile_scheduler.sv
// Sequences one K-tile accumulation job: fetch tile, pulse SA load, wait weight-valid, repeat, then wait output-valid.
// Latency: 3 cycles per tile minimum plus ack/SA delays; O_DONE one cycle after the final output-valid.
// Backpressure: holds the read request until ack and every wait until its valid; a wait of TIMEOUT_CYC cycles aborts with O_ERR.
module sa_tile_scheduler #(
   parameter int A_W         = 12,
   parameter int KT_W        = 6,
   parameter int TILE_STRIDE = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   sa_tile_scheduler_if.slave  bus
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_WAIT_LD,
      ST_WAIT_OUT,
      ST_DONE
   } state_t;

   state_t            r_state;
   logic [KT_W-1:0]   r_k;
   logic [KT_W-1:0]   r_idx;
   logic [A_W-1:0]    r_rd_addr;
   logic [TMR_W-1:0]  r_tmr;
   logic              r_busy;
   logic              r_rd_req;
   logic              r_load_flag;
   logic              r_acc;
   logic              r_done;
   logic              r_err;

   // The timer counts cycles already spent in the current wait state.
   wire w_tmo  = (r_tmr == TMR_W'(TIMEOUT_CYC - 1));
   wire w_last = (r_idx == r_k - KT_W'(1));

   assign bus.o_busy          = r_busy;
   assign bus.o_rd_req        = r_rd_req;
   assign bus.o_rd_addr       = r_rd_addr;
   assign bus.o_sa_load_flag  = r_load_flag;
   assign bus.o_sa_accumulate = r_acc;
   assign bus.o_tile_idx      = r_idx;
   assign bus.o_done          = r_done;
   assign bus.o_err           = r_err;

   // Job FSM with all outputs registered on the transition into each state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_k         <= '0;
         r_idx       <= '0;
         r_rd_addr   <= '0;
         r_tmr       <= '0;
         r_busy      <= 1'b0;
         r_rd_req    <= 1'b0;
         r_load_flag <= 1'b0;
         r_acc       <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  r_busy <= 1'b1;
                  if (bus.i_k_tiles != '0) begin
                     r_k       <= bus.i_k_tiles;
                     r_idx     <= '0;
                     r_rd_addr <= bus.i_base_addr;
                     r_rd_req  <= 1'b1;
                     r_err     <= 1'b0;
                     r_tmr     <= '0;
                     r_state   <= ST_FETCH;
                  end else begin
                     // An empty job is reported as an error without touching the buffer.
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_FETCH: begin
               // A late ack still wins over an expiring timer.
               if (bus.i_rd_ack) begin
                  r_rd_req    <= 1'b0;
                  r_load_flag <= 1'b1;
                  r_acc       <= (r_idx != '0);
                  r_state     <= ST_LOAD;
               end else if (w_tmo) begin
                  r_rd_req <= 1'b0;
                  r_err    <= 1'b1;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            ST_LOAD: begin
               r_load_flag <= 1'b0;
               r_tmr       <= '0;
               r_state     <= ST_WAIT_LD;
            end
            ST_WAIT_LD: begin
               if (bus.i_sa_load_weight_vld) begin
                  r_tmr <= '0;
                  if (!w_last) begin
                     // Address advances by one stride and wraps at the buffer size.
                     r_idx     <= r_idx + KT_W'(1);
                     r_rd_addr <= r_rd_addr + A_W'(TILE_STRIDE);
                     r_rd_req  <= 1'b1;
                     r_state   <= ST_FETCH;
                  end else begin
                     r_state <= ST_WAIT_OUT;
                  end
               end else if (w_tmo) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            ST_WAIT_OUT: begin
               if (bus.i_sa_out_vld) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_tmo) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_idx   <= '0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler: a responder models buffer acks and SA valids, a monitor logs activity.
// Latency: checks per-tile address/accumulate sequences, ack hold length, timeout distance and reset behaviour.
// Backpressure: ack delay and weight-valid delay are programmable per test.
module tb_sa_tile_scheduler;

   localparam int A_W         = 12;
   localparam int KT_W        = 6;
   localparam int TILE_STRIDE = 16;
   localparam int TIMEOUT_CYC = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   // Free-running clock.
   always #5 clk = ~clk;

   sa_tile_scheduler_if #(.A_W(A_W), .KT_W(KT_W)) u_if ();

   sa_tile_scheduler #(
      .A_W(A_W), .KT_W(KT_W), .TILE_STRIDE(TILE_STRIDE), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (u_if)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor state, written only by the monitor process.
   int              cyc      = 0;
   int              load_cnt = 0;
   int              done_cnt = 0;
   int              load_cyc = 0;
   int              done_cyc = 0;
   int              hold_err = 0;
   int              run      = 0;
   logic            prev_req = 1'b0;
   logic [A_W-1:0]  last_addr = '0;
   logic [A_W-1:0]  addr_q[$];
   int              len_q[$];
   logic            acc_q[$];

   // Logs fetches (address and request length), load pulses with accumulate, and done pulses.
   always @(negedge clk) begin
      cyc++;
      if (u_if.o_rd_req) begin
         if (!prev_req) begin
            addr_q.push_back(u_if.o_rd_addr);
            run = 1;
         end else begin
            run++;
            if (u_if.o_rd_addr !== last_addr) hold_err++;
         end
         last_addr = u_if.o_rd_addr;
      end else if (prev_req) begin
         len_q.push_back(run);
      end
      prev_req = u_if.o_rd_req;
      if (u_if.o_sa_load_flag) begin
         load_cnt++;
         load_cyc = cyc;
         acc_q.push_back(u_if.o_sa_accumulate);
      end
      if (u_if.o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // Responder knobs, written by the main sequence.
   int ack_delay_tile = -1;
   int ack_delay      = 0;
   int ld_delay       = 0;
   int cur_k          = 1;
   bit ld_en          = 1'b1;
   bit out_en         = 1'b1;

   // Tile buffer and SA_wrapper model.
   initial begin : responder
      int ack_cnt;
      int ld_cnt;
      int out_cnt;
      ack_cnt = 0;
      ld_cnt  = 0;
      out_cnt = 0;
      u_if.i_rd_ack             = 1'b0;
      u_if.i_sa_load_weight_vld = 1'b0;
      u_if.i_sa_out_vld         = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (u_if.o_rd_req && !u_if.i_rd_ack) begin
            if (ack_cnt >= ((int'(u_if.o_tile_idx) == ack_delay_tile) ? ack_delay : 0))
               u_if.i_rd_ack = 1'b1;
            else
               ack_cnt++;
         end else begin
            u_if.i_rd_ack = 1'b0;
            ack_cnt = 0;
         end
         u_if.i_sa_load_weight_vld = 1'b0;
         u_if.i_sa_out_vld         = 1'b0;
         if (out_cnt > 0) begin
            out_cnt--;
            if (out_cnt == 0 && out_en) u_if.i_sa_out_vld = 1'b1;
         end
         if (u_if.o_sa_load_flag) begin
            ld_cnt = ld_delay + 1;
         end else if (ld_cnt > 0) begin
            ld_cnt--;
            if (ld_cnt == 0 && ld_en) begin
               u_if.i_sa_load_weight_vld = 1'b1;
               if (int'(u_if.o_tile_idx) == cur_k - 1) out_cnt = 3;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int k, input int base);
      @(posedge clk);
      #1;
      u_if.i_start     = 1'b1;
      u_if.i_k_tiles   = KT_W'(k);
      u_if.i_base_addr = A_W'(base);
      @(posedge clk);
      #1;
      u_if.i_start = 1'b0;
   endtask

   // Returns just after the negedge at which a new O_DONE pulse was logged, or after the bound.
   task automatic wait_done(input string tag, input int d0, input int bound);
      int n;
      n = 0;
      while (done_cnt == d0 && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({tag, "_done_seen"}, done_cnt - d0, 1);
   endtask

   task automatic wait_load(input string tag, input int l0, input int bound);
      int n;
      n = 0;
      while (load_cnt == l0 && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({tag, "_load_seen"}, load_cnt - l0, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, u_if.o_busy, 0);
      chk({tag, "_rd_req"}, u_if.o_rd_req, 0);
      chk({tag, "_rd_addr"}, u_if.o_rd_addr, 0);
      chk({tag, "_load_flag"}, u_if.o_sa_load_flag, 0);
      chk({tag, "_acc"}, u_if.o_sa_accumulate, 0);
      chk({tag, "_tile_idx"}, u_if.o_tile_idx, 0);
      chk({tag, "_done"}, u_if.o_done, 0);
      chk({tag, "_err"}, u_if.o_err, 0);
   endtask

   // Global guard against a hung sequence.
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: sequence did not complete, checks=%0d", n_chk);
      $fatal(1);
   end

   // Directed test sequence.
   initial begin : main
      int a0, l0, d0, n0;
      u_if.i_start     = 1'b0;
      u_if.i_k_tiles   = '0;
      u_if.i_base_addr = '0;
      rst_n = 1'b0;
      tick(3);
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // K=3 from 0x010 with immediate acks.
      a0 = addr_q.size(); l0 = acc_q.size(); d0 = done_cnt; cur_k = 3;
      start_job(3, 'h010);
      wait_done("t1", d0, 200);
      chk("t1_err", u_if.o_err, 0);
      tick(3);
      chk("t1_fetches", addr_q.size() - a0, 3);
      chk("t1_addr0", addr_q[a0], 'h010);
      chk("t1_addr1", addr_q[a0+1], 'h020);
      chk("t1_addr2", addr_q[a0+2], 'h030);
      chk("t1_loads", acc_q.size() - l0, 3);
      chk("t1_acc0", acc_q[l0], 0);
      chk("t1_acc1", acc_q[l0+1], 1);
      chk("t1_acc2", acc_q[l0+2], 1);
      chk("t1_done_once", done_cnt - d0, 1);
      chk("t1_busy_after", u_if.o_busy, 0);
      chk("t1_idx_after", u_if.o_tile_idx, 0);

      // Ack for tile 1 delayed by 5 cycles.
      ack_delay_tile = 1; ack_delay = 5;
      n0 = len_q.size(); l0 = load_cnt; d0 = done_cnt; cur_k = 2;
      start_job(2, 'h200);
      wait_done("t2", d0, 200);
      tick(2);
      chk("t2_len0", len_q[n0], 1);
      chk("t2_len1", len_q[n0+1], 6);
      chk("t2_loads", load_cnt - l0, 2);
      chk("t2_addr_hold", hold_err, 0);
      ack_delay_tile = -1; ack_delay = 0;

      // K=0 is an error with no reads.
      a0 = addr_q.size(); d0 = done_cnt;
      start_job(0, 'h123);
      wait_done("t3", d0, 10);
      chk("t3_err", u_if.o_err, 1);
      chk("t3_busy", u_if.o_busy, 1);
      tick(3);
      chk("t3_fetches", addr_q.size() - a0, 0);
      chk("t3_done_once", done_cnt - d0, 1);

      // Weight-valid never comes: timeout in WAIT_LD.
      ld_en = 1'b0; cur_k = 1; l0 = load_cnt; d0 = done_cnt;
      start_job(1, 'h300);
      wait_done("t4", d0, 100);
      chk("t4_err", u_if.o_err, 1);
      chk("t4_tmo_dist", done_cyc - load_cyc, TIMEOUT_CYC + 1);
      chk("t4_loads", load_cnt - l0, 1);
      ld_en = 1'b1;
      tick(2);
      d0 = done_cnt;
      start_job(1, 'h300);
      chk("t4_err_cleared", u_if.o_err, 0);
      chk("t4_busy", u_if.o_busy, 1);
      wait_done("t4b", d0, 100);
      chk("t4b_err", u_if.o_err, 0);
      tick(2);

      // Start pulse during WAIT_LD of a K=2 job is ignored.
      ld_delay = 6; cur_k = 2; a0 = addr_q.size(); l0 = load_cnt; d0 = done_cnt;
      start_job(2, 'h100);
      wait_load("t5", l0, 20);
      tick(2);
      start_job(5, 'h400);
      wait_done("t5", d0, 200);
      tick(10);
      chk("t5_fetches", addr_q.size() - a0, 2);
      chk("t5_addr0", addr_q[a0], 'h100);
      chk("t5_addr1", addr_q[a0+1], 'h110);
      chk("t5_done_once", done_cnt - d0, 1);
      chk("t5_busy_after", u_if.o_busy, 0);
      ld_delay = 0;

      // Reset while waiting for output-valid.
      out_en = 1'b0; cur_k = 1; l0 = load_cnt; d0 = done_cnt;
      start_job(1, 'h050);
      wait_load("t6", l0, 20);
      tick(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("t6_rst");
      @(negedge clk);
      rst_n = 1'b1;
      out_en = 1'b1;
      tick(5);
      chk("t6_no_done", done_cnt - d0, 0);
      a0 = addr_q.size(); d0 = done_cnt; cur_k = 2;
      start_job(2, 'h080);
      wait_done("t6b", d0, 200);
      chk("t6b_err", u_if.o_err, 0);
      tick(2);
      chk("t6b_fetches", addr_q.size() - a0, 2);

      // Address wrap at the top of the buffer.
      a0 = addr_q.size(); d0 = done_cnt; cur_k = 2;
      start_job(2, 'hFF0);
      wait_done("t7", d0, 200);
      tick(2);
      chk("t7_addr0", addr_q[a0], 'hFF0);
      chk("t7_addr1", addr_q[a0+1], 'h000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
